// File: rtl/int_arbiter_pkg.sv
// Shared types and limits for the interrupt arbiter.
// States and the source-count ceiling used by the arbiter and its priority tree.
package int_arbiter_pkg;

    localparam int unsigned MAX_INTS = 64;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        HOLD
    } int_arb_state_t;

endpackage

// File: rtl/int_arbiter_if.sv
// Signal bundle between the interrupt sources/CSRs and the trap unit.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface int_arbiter_if #(
    parameter int unsigned NUM_INTS = 16,
    parameter int unsigned PRIO_W   = 3,
    parameter int unsigned ID_W     = $clog2(NUM_INTS)
) ();

    logic [NUM_INTS-1:0]        IntSrc;
    logic [NUM_INTS-1:0]        IntEdge;
    logic [NUM_INTS-1:0]        IntEn;
    logic [NUM_INTS-1:0]        IntDeleg;
    logic [NUM_INTS*PRIO_W-1:0] IntPrio;
    logic [1:0]                 PrivilegeModeW;
    logic                       STATUS_MIE;
    logic                       STATUS_SIE;
    logic                       Committed;
    logic                       InstrValidM;
    logic                       wfiM;
    logic                       TakeM;
    logic                       IntReqM;
    logic [ID_W-1:0]            IntIdM;
    logic                       IntToSM;
    logic                       IntPendingM;
    logic                       WfiWakeM;
    logic [NUM_INTS-1:0]        PendingQ;

    modport slave (
        input  IntSrc, IntEdge, IntEn, IntDeleg, IntPrio, PrivilegeModeW,
        input  STATUS_MIE, STATUS_SIE, Committed, InstrValidM, wfiM, TakeM,
        output IntReqM, IntIdM, IntToSM, IntPendingM, WfiWakeM, PendingQ
    );

    modport master (
        output IntSrc, IntEdge, IntEn, IntDeleg, IntPrio, PrivilegeModeW,
        output STATUS_MIE, STATUS_SIE, Committed, InstrValidM, wfiM, TakeM,
        input  IntReqM, IntIdM, IntToSM, IntPendingM, WfiWakeM, PendingQ
    );

endinterface

// File: rtl/int_prio_tree.sv
// Combinational log-depth max-finder over (key, index); the lowest index wins on equal keys.
// Keys are compared as unsigned numbers, so callers pack class above priority.
module int_prio_tree
    import int_arbiter_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned KeyW = 4,
    parameter int unsigned IdW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      valid_i,
    input  logic [N*KeyW-1:0] key_i,
    output logic              valid_o,
    output logic [IdW-1:0]    id_o
);

    localparam int unsigned Levels = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned Pad    = 1 << Levels;

    logic            vld [Pad];
    logic [KeyW-1:0] kv  [Pad];
    logic [IdW-1:0]  idx [Pad];

    always_comb begin
        for (int i = 0; i < int'(Pad); i++) begin
            if (i < int'(N)) begin
                vld[i] = valid_i[i];
                kv[i]  = key_i[i*KeyW +: KeyW];
            end else begin
                vld[i] = 1'b0;
                kv[i]  = '0;
            end
            idx[i] = IdW'(i);
        end
        // Pairwise reduction in place; the right (higher-index) side only wins on a strictly larger key.
        for (int l = 0; l < int'(Levels); l++) begin
            for (int j = 0; j < int'(Pad >> (l + 1)); j++) begin
                if (vld[2*j+1] && (!vld[2*j] || (kv[2*j+1] > kv[2*j]))) begin
                    vld[j] = vld[2*j+1];
                    kv[j]  = kv[2*j+1];
                    idx[j] = idx[2*j+1];
                end else begin
                    vld[j] = vld[2*j];
                    kv[j]  = kv[2*j];
                    idx[j] = idx[2*j];
                end
            end
        end
        valid_o = vld[0];
        id_o    = idx[0];
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge/level pending capture, class/priority arbitration, and a latched
// presentation to the trap unit that is held until claimed or strictly preempted.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INTS = 16,
    parameter int unsigned PRIO_W   = 3,
    parameter int unsigned ID_W     = $clog2(NUM_INTS)
) (
    input logic          clk,
    input logic          reset_n,
    int_arbiter_if.slave bus
);

    localparam int unsigned KeyW = PRIO_W + 1;

    logic [NUM_INTS-1:0]      src_q, src_d;
    logic [NUM_INTS-1:0]      pending_q, pending_d;
    logic [NUM_INTS-1:0]      cand, edge_set, claim_clr;
    logic [PRIO_W-1:0]        prio [NUM_INTS];
    logic [NUM_INTS*KeyW-1:0] keys;
    logic                     m_en, s_en;

    logic                     win_valid;
    logic [ID_W-1:0]          win_id;
    logic [KeyW-1:0]          win_key, lat_key;
    logic                     cmp_valid;
    logic [0:0]               cmp_id;
    logic                     preempt;

    int_arb_state_t           state_q, state_d;
    logic [ID_W-1:0]          int_id_q, int_id_d;
    logic                     int_to_s_q, int_to_s_d;
    logic                     armed_q;
    logic                     wake_q, wake_d;

    assign m_en = (bus.PrivilegeModeW != 2'b11) | bus.STATUS_MIE;
    assign s_en = (bus.PrivilegeModeW == 2'b00) | ((bus.PrivilegeModeW == 2'b01) & bus.STATUS_SIE);

    // Key = {not delegated, priority}: any M-class candidate outranks any S-class one.
    always_comb begin
        for (int i = 0; i < int'(NUM_INTS); i++) begin
            prio[i]                 = bus.IntPrio[i*PRIO_W +: PRIO_W];
            keys[i*KeyW +: KeyW]    = {~bus.IntDeleg[i], prio[i]};
            cand[i] = pending_q[i] & bus.IntEn[i] & (prio[i] != '0)
                      & (bus.IntDeleg[i] ? s_en : m_en);
        end
    end

    int_prio_tree #(
        .N    (NUM_INTS),
        .KeyW (KeyW),
        .IdW  (ID_W)
    ) u_arb_tree (
        .valid_i (cand),
        .key_i   (keys),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    assign win_key = {~bus.IntDeleg[win_id], prio[win_id]};
    assign lat_key = {~int_to_s_q, prio[int_id_q]};

    // Latched entry sits at index 0, so an equal key keeps it and only a strict win preempts.
    int_prio_tree #(
        .N    (2),
        .KeyW (KeyW),
        .IdW  (1)
    ) u_cmp_tree (
        .valid_i (2'b11),
        .key_i   ({win_key, lat_key}),
        .valid_o (cmp_valid),
        .id_o    (cmp_id)
    );

    assign preempt = win_valid & cmp_valid & cmp_id[0];

    always_comb begin
        src_d      = bus.IntSrc;
        // Lines already high when reset releases do not count as a fresh edge.
        edge_set   = armed_q ? (bus.IntSrc & ~src_q) : '0;
        claim_clr  = '0;
        state_d    = state_q;
        int_id_d   = int_id_q;
        int_to_s_d = int_to_s_q;

        unique case (state_q)
            IDLE: begin
                if (win_valid && !bus.Committed) begin
                    state_d    = PRESENT;
                    int_id_d   = win_id;
                    int_to_s_d = bus.IntDeleg[win_id];
                end
            end
            PRESENT: begin
                if (bus.TakeM) begin
                    state_d             = HOLD;
                    claim_clr[int_id_q] = 1'b1;
                end else if (!cand[int_id_q]) begin
                    state_d = IDLE;
                end else if (preempt) begin
                    int_id_d   = win_id;
                    int_to_s_d = bus.IntDeleg[win_id];
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pending_d = (bus.IntEdge & ((pending_q & ~claim_clr) | edge_set))
                  | (~bus.IntEdge & bus.IntSrc);
        wake_d    = bus.wfiM & bus.IntPendingM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= '0;
            pending_q  <= '0;
            state_q    <= IDLE;
            int_id_q   <= '0;
            int_to_s_q <= 1'b0;
            armed_q    <= 1'b0;
            wake_q     <= 1'b0;
        end else begin
            src_q      <= src_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            int_id_q   <= int_id_d;
            int_to_s_q <= int_to_s_d;
            armed_q    <= 1'b1;
            wake_q     <= wake_d;
        end
    end

    // WFI does not gate the request; the trap unit retires the WFI through the wake pulse.
    assign bus.IntReqM     = (state_q == PRESENT) & bus.InstrValidM & ~bus.Committed;
    assign bus.IntIdM      = int_id_q;
    assign bus.IntToSM     = int_to_s_q;
    assign bus.IntPendingM = |(pending_q & bus.IntEn);
    assign bus.WfiWakeM    = bus.wfiM & bus.IntPendingM & ~wake_q;
    assign bus.PendingQ    = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: vector table, randomized trials against a scoring
// model, and directed multi-cycle sequences (claim, preemption, commit, WFI, reset).
module tb_int_arbiter;

    localparam int N  = 16;
    localparam int PW = 3;
    localparam int IW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int_arbiter_if #(.NUM_INTS(N), .PRIO_W(PW), .ID_W(IW)) bus ();

    int_arbiter #(.NUM_INTS(N), .PRIO_W(PW), .ID_W(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]  priv;
        logic        mie;
        logic        sie;
        logic [15:0] src;
        logic [15:0] deleg;
        logic        req;
        logic [3:0]  id;
        logic        tos;
        logic        pend;
    } vec_t;

    vec_t tbl [10];

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]  r_priv;
    logic        r_mie, r_sie, men, sen;
    logic [15:0] r_src, r_en, r_deleg;
    logic [47:0] r_prio;
    int          best, best_score, p, score;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic defaults();
        bus.IntSrc         = '0;
        bus.IntEdge        = '0;
        bus.IntEn          = '1;
        bus.IntDeleg       = '0;
        bus.IntPrio        = '0;
        bus.PrivilegeModeW = 2'd3;
        bus.STATUS_MIE     = 1'b1;
        bus.STATUS_SIE     = 1'b0;
        bus.Committed      = 1'b0;
        bus.InstrValidM    = 1'b1;
        bus.wfiM           = 1'b0;
        bus.TakeM          = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        defaults();
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic set_prio(input int i, input int pr);
        bus.IntPrio[i*PW +: PW] = PW'(pr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Source i has priority i mod 8; all sources level-sensitive and enabled.
        tbl[0] = '{2'd3, 1'b1, 1'b0, 16'h000E, 16'h0000, 1'b1, 4'd3,  1'b0, 1'b1};
        tbl[1] = '{2'd3, 1'b1, 1'b0, 16'h8080, 16'h0000, 1'b1, 4'd7,  1'b0, 1'b1};
        tbl[2] = '{2'd3, 1'b1, 1'b0, 16'h0101, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[3] = '{2'd3, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[4] = '{2'd0, 1'b0, 1'b0, 16'h0060, 16'h0040, 1'b1, 4'd5,  1'b0, 1'b1};
        tbl[5] = '{2'd1, 1'b0, 1'b0, 16'h0040, 16'h0040, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[6] = '{2'd1, 1'b0, 1'b1, 16'h4040, 16'h4040, 1'b1, 4'd6,  1'b1, 1'b1};
        tbl[7] = '{2'd3, 1'b1, 1'b0, 16'h2008, 16'h2000, 1'b1, 4'd3,  1'b0, 1'b1};
        tbl[8] = '{2'd3, 1'b1, 1'b0, 16'h1010, 16'h0000, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[9] = '{2'd1, 1'b0, 1'b1, 16'h0600, 16'h0400, 1'b1, 4'd9,  1'b0, 1'b1};

        // Reset with all lines high, all edge-sensitive.
        defaults();
        bus.IntSrc  = '1;
        bus.IntEdge = '1;
        bus.IntPrio = {16{3'd1}};
        #1 reset_n = 1'b0;
        cyc(1);
        look();
        chk("rst_req",  32'(bus.IntReqM),     32'd0);
        chk("rst_id",   32'(bus.IntIdM),      32'd0);
        chk("rst_tos",  32'(bus.IntToSM),     32'd0);
        chk("rst_pend", 32'(bus.IntPendingM), 32'd0);
        chk("rst_wake", 32'(bus.WfiWakeM),    32'd0);
        chk("rst_pq",   32'(bus.PendingQ),    32'd0);
        reset_n = 1'b1;
        cyc(3);
        look();
        chk("post_rst_pq",   32'(bus.PendingQ),    32'd0);
        chk("post_rst_pend", 32'(bus.IntPendingM), 32'd0);
        chk("post_rst_req",  32'(bus.IntReqM),     32'd0);
        bus.IntSrc = '0;
        cyc(1);
        bus.IntSrc = 16'h0008;
        cyc(1);
        look();
        chk("fresh_edge_pq", 32'(bus.PendingQ), 32'h0008);
        cyc(1);
        look();
        chk("fresh_edge_req", 32'(bus.IntReqM), 32'd1);
        chk("fresh_edge_id",  32'(bus.IntIdM),  32'd3);

        // Vector table.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) set_prio(i, i % 8);
            bus.PrivilegeModeW = tbl[v].priv;
            bus.STATUS_MIE     = tbl[v].mie;
            bus.STATUS_SIE     = tbl[v].sie;
            bus.IntDeleg       = tbl[v].deleg;
            bus.IntSrc         = tbl[v].src;
            cyc(3);
            look();
            chk($sformatf("tbl%0d_req", v),  32'(bus.IntReqM),     32'(tbl[v].req));
            chk($sformatf("tbl%0d_pend", v), 32'(bus.IntPendingM), 32'(tbl[v].pend));
            if (tbl[v].req) begin
                chk($sformatf("tbl%0d_id", v),  32'(bus.IntIdM),  32'(tbl[v].id));
                chk($sformatf("tbl%0d_tos", v), 32'(bus.IntToSM), 32'(tbl[v].tos));
            end
        end

        // Randomized level-mode trials against a linear best-score scan.
        for (int t = 0; t < 30; t++) begin
            do_reset();
            r_priv  = 2'($urandom_range(0, 3));
            r_mie   = 1'($urandom_range(0, 1));
            r_sie   = 1'($urandom_range(0, 1));
            r_src   = 16'($urandom);
            r_en    = 16'($urandom);
            r_deleg = 16'($urandom);
            r_prio  = 48'({$urandom, $urandom});
            bus.PrivilegeModeW = r_priv;
            bus.STATUS_MIE     = r_mie;
            bus.STATUS_SIE     = r_sie;
            bus.IntEn          = r_en;
            bus.IntDeleg       = r_deleg;
            bus.IntPrio        = r_prio;
            bus.IntSrc         = r_src;
            cyc(3);
            look();
            men = (r_priv != 2'd3) || r_mie;
            sen = (r_priv == 2'd0) || ((r_priv == 2'd1) && r_sie);
            best = -1;
            best_score = -1;
            for (int i = 0; i < N; i++) begin
                p = int'(r_prio[i*PW +: PW]);
                if (r_src[i] && r_en[i] && p != 0 && (r_deleg[i] ? sen : men)) begin
                    score = (r_deleg[i] ? 0 : 8) + p;
                    if (score > best_score) begin
                        best = i;
                        best_score = score;
                    end
                end
            end
            chk($sformatf("rnd%0d_req", t),  32'(bus.IntReqM),     32'(best >= 0));
            chk($sformatf("rnd%0d_pend", t), 32'(bus.IntPendingM), 32'(|(r_src & r_en)));
            chk($sformatf("rnd%0d_pq", t),   32'(bus.PendingQ),    32'(r_src));
            if (best >= 0) begin
                chk($sformatf("rnd%0d_id", t),  32'(bus.IntIdM),  32'(best));
                chk($sformatf("rnd%0d_tos", t), 32'(bus.IntToSM), 32'(r_deleg[best]));
            end
        end

        // Level source 7: claim leaves it pending and it is re-presented.
        do_reset();
        set_prio(7, 3);
        bus.IntSrc[7] = 1'b1;
        cyc(1);
        look();
        chk("lvl_pq_t1",  32'(bus.PendingQ), 32'h0080);
        chk("lvl_req_t1", 32'(bus.IntReqM),  32'd0);
        cyc(1);
        look();
        chk("lvl_req_t2", 32'(bus.IntReqM), 32'd1);
        chk("lvl_id_t2",  32'(bus.IntIdM),  32'd7);
        bus.TakeM = 1'b1;
        cyc(1);
        bus.TakeM = 1'b0;
        look();
        chk("lvl_req_hold", 32'(bus.IntReqM),  32'd0);
        chk("lvl_pq_hold",  32'(bus.PendingQ), 32'h0080);
        cyc(1);
        look();
        chk("lvl_req_t4", 32'(bus.IntReqM), 32'd0);
        cyc(1);
        look();
        chk("lvl_req_t5", 32'(bus.IntReqM), 32'd1);
        chk("lvl_id_t5",  32'(bus.IntIdM),  32'd7);
        reset_n = 1'b0;
        look();
        chk("async_rst_req", 32'(bus.IntReqM),  32'd0);
        chk("async_rst_pq",  32'(bus.PendingQ), 32'd0);

        // Equal-priority edge sources 2 and 9.
        do_reset();
        bus.IntEdge = '1;
        set_prio(2, 5);
        set_prio(9, 5);
        bus.IntSrc = 16'h0204;
        cyc(2);
        look();
        chk("tie_req", 32'(bus.IntReqM), 32'd1);
        chk("tie_id",  32'(bus.IntIdM),  32'd2);
        bus.TakeM = 1'b1;
        cyc(1);
        bus.TakeM = 1'b0;
        look();
        chk("tie_pq_hold",  32'(bus.PendingQ), 32'h0200);
        chk("tie_req_hold", 32'(bus.IntReqM),  32'd0);
        cyc(2);
        look();
        chk("tie_req_next", 32'(bus.IntReqM), 32'd1);
        chk("tie_id_next",  32'(bus.IntIdM),  32'd9);

        // Delegated prio 7 versus non-delegated prio 1.
        do_reset();
        set_prio(4, 7);
        set_prio(1, 1);
        bus.IntDeleg       = 16'h0010;
        bus.PrivilegeModeW = 2'd1;
        bus.STATUS_SIE     = 1'b1;
        bus.STATUS_MIE     = 1'b0;
        bus.IntSrc         = 16'h0012;
        cyc(2);
        look();
        chk("deleg_req", 32'(bus.IntReqM), 32'd1);
        chk("deleg_id",  32'(bus.IntIdM),  32'd1);
        chk("deleg_tos", 32'(bus.IntToSM), 32'd0);
        do_reset();
        set_prio(4, 7);
        set_prio(1, 1);
        bus.IntDeleg   = 16'h0010;
        bus.STATUS_MIE = 1'b0;
        bus.IntSrc     = 16'h0012;
        cyc(3);
        look();
        chk("mmode_req",  32'(bus.IntReqM),     32'd0);
        chk("mmode_pend", 32'(bus.IntPendingM), 32'd1);

        // Committed blocks presentation; then WFI wake pulse.
        do_reset();
        set_prio(3, 1);
        bus.Committed = 1'b1;
        bus.IntSrc    = 16'h0008;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            look();
            chk($sformatf("commit_req%0d", c), 32'(bus.IntReqM), 32'd0);
        end
        bus.Committed = 1'b0;
        cyc(1);
        look();
        chk("commit_drop_req", 32'(bus.IntReqM), 32'd1);
        chk("commit_drop_id",  32'(bus.IntIdM),  32'd3);
        bus.wfiM = 1'b1;
        look();
        chk("wfi_wake",    32'(bus.WfiWakeM), 32'd1);
        chk("wfi_req",     32'(bus.IntReqM),  32'd1);
        cyc(1);
        look();
        chk("wfi_wake_end", 32'(bus.WfiWakeM), 32'd0);
        bus.wfiM = 1'b0;

        // Strict preemption, then same-cycle edge and claim of source 6.
        do_reset();
        bus.IntEdge = '1;
        set_prio(5, 2);
        set_prio(6, 6);
        bus.IntSrc = 16'h0020;
        cyc(2);
        look();
        chk("pre_req5", 32'(bus.IntReqM), 32'd1);
        chk("pre_id5",  32'(bus.IntIdM),  32'd5);
        bus.IntSrc = 16'h0060;
        cyc(1);
        look();
        chk("pre_id_still5", 32'(bus.IntIdM), 32'd5);
        cyc(1);
        look();
        chk("pre_req6", 32'(bus.IntReqM), 32'd1);
        chk("pre_id6",  32'(bus.IntIdM),  32'd6);
        bus.IntSrc[6] = 1'b0;
        cyc(1);
        bus.IntSrc[6] = 1'b1;
        bus.TakeM     = 1'b1;
        cyc(1);
        bus.TakeM = 1'b0;
        look();
        chk("edge_claim_pq6",  32'(bus.PendingQ[6]), 32'd1);
        chk("edge_claim_req",  32'(bus.IntReqM),     32'd0);
        cyc(2);
        look();
        chk("edge_claim_rereq", 32'(bus.IntReqM), 32'd1);
        chk("edge_claim_reid",  32'(bus.IntIdM),  32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Parametrised interrupt arbiter that generalises the privileged unit's fixed 12-bit interrupt prioritisation to NUM_INTS sources. It supports per-source edge/level sensing, programmable priority and M/S delegation. It latches a winning interrupt and holds it stable until the trap logic claims it, defers presentation while the memory system is committed, and generates a WFI wake pulse. It sits between the CLINT/PLIC-style interrupt lines and the trap unit in the M stage.

## Interface
- NUM_INTS, 16, number of interrupt sources (2..64)
- PRIO_W, 3, priority field width per source; priority 0 = never selected
- ID_W, $clog2(NUM_INTS), derived width of the interrupt ID
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- IntSrc  in  NUM_INTS  raw interrupt lines, synchronous to clk
- IntEdge  in  NUM_INTS  1 = rising-edge sensitive, 0 = level sensitive
- IntEn  in  NUM_INTS  per-source enable (MIE equivalent)
- IntDeleg  in  NUM_INTS  1 = delegated to S mode (MIDELEG equivalent)
- IntPrio  in  NUM_INTS*PRIO_W  packed priorities; source i at [i*PRIO_W +: PRIO_W]
- PrivilegeModeW  in  2  current privilege (U=0, S=1, M=3)
- STATUS_MIE, STATUS_SIE  in  1 each  global enables
- Committed  in  1  IFU/LSU committed to an uninterruptible bus operation
- InstrValidM  in  1  valid instruction in M stage
- wfiM  in  1  WFI in M stage
- TakeM  in  1  trap unit accepts the presented interrupt this cycle
- IntReqM  out  1  interrupt presented to the trap unit
- IntIdM  out  ID_W  ID of the presented interrupt
- IntToSM  out  1  presented interrupt is delegated to S
- IntPendingM  out  1  any pending & enabled source, ignoring global enables
- WfiWakeM  out  1  one-cycle wake pulse
- PendingQ  out  NUM_INTS  registered pending vector (MIP readback)

## Operation
- Sampling: SrcQ <= IntSrc each cycle. Edge source: PendingQ[i] set when IntSrc[i] & ~SrcQ[i]; cleared on claim; set dominates a same-cycle clear. Level source: PendingQ[i] <= IntSrc[i]; claims have no effect.
- Global enables: MEn = (Priv != M) | STATUS_MIE; SEn = (Priv == U) | (Priv == S & STATUS_SIE).
- Candidates: PendingQ & IntEn & prio != 0 & (IntDeleg ? SEn : MEn).
- Winner selection:
  - Any non-delegated candidate beats any delegated one.
  - Within a class, the highest IntPrio wins; ties go to the lowest index.
- FSM states IDLE, PRESENT, HOLD:
  - IDLE -> PRESENT when a candidate exists and ~Committed; the winner ID and class are latched.
  - PRESENT -> HOLD on TakeM. The claim clears PendingQ[IntIdQ] if that source is edge-sensitive.
  - PRESENT -> IDLE if the latched source is no longer a candidate and TakeM is low.
  - In PRESENT, the latch is updated to a new winner only if it strictly outranks the latched one; the state stays PRESENT.
  - HOLD -> IDLE unconditionally, so the cleared pending bit propagates before re-arbitration.
- IntReqM = (state == PRESENT) & InstrValidM & ~Committed & (~wfiM | TakeM-ready). With wfiM high, the request is still asserted; the WFI is retired via WfiWakeM.
- IntIdM and IntToSM come from the latch and are stable whenever IntReqM is high, except on a strict preemption.
- IntPendingM = |(PendingQ & IntEn).
- WfiWakeM pulses for one cycle on the rising edge of (wfiM & IntPendingM).

## Timing
- Reset (reset_n low, asynchronous): SrcQ, PendingQ and latches = 0; state IDLE; all outputs 0.
- Release is synchronous to clk.
- Latency: IntSrc rises at edge t -> PendingQ at t+1 -> PRESENT at t+2 -> IntReqM high in cycle t+2 if gated in.
- Claim: TakeM at t -> HOLD at t+1 -> IDLE at t+2 -> next winner PRESENT at t+3 at the earliest.
- Committed high in IDLE blocks the transition; in PRESENT it masks IntReqM only, and the latch is kept.
- An edge during a claim of the same source stays pending and is re-presented after HOLD.
- A reset asserted mid-PRESENT drops IntReqM immediately (asynchronously).

## Structure
- Put in cvw package: int_arb_state_t enum {IDLE, PRESENT, HOLD}; MAX_INTS = 64.
- One sub-module, int_prio_tree: combinational, parametrised log-depth (class, prio, index) max-finder with lowest-index tie-break, used for both arbitration and the preemption compare.

## Test plan
- Reset with IntSrc = all ones, reset_n low -> all outputs 0; after release with all edge-mode, no pending until a fresh 0->1 edge.
- Level source 7, prio 3, M mode, MIE=1, raise at t -> IntReqM=1, IntIdM=7 at t+2; TakeM -> PendingQ[7] stays 1, re-presented at t+5.
- Edge sources 2 (prio 5) and 9 (prio 5) together -> IntIdM=2; claim -> IntIdM=9 three cycles later.
- Delegated source 4 (prio 7) vs non-delegated source 1 (prio 1), S mode, SIE=1 -> IntIdM=1, IntToSM=0; in M mode with MIE=0 -> IntReqM=0, IntPendingM=1.
- Committed=1 for 10 cycles with source 3 pending -> IntReqM=0 throughout, asserted the cycle after Committed drops; wfiM with source pending -> a single-cycle WfiWakeM.
- Source 5 (prio 2) presented, source 6 (prio 6) edge arrives -> IntIdM switches to 6 with no IDLE cycle; same-cycle edge and claim of source 6 -> PendingQ[6] remains 1.
